instr_sequencer: RTL

//  Multi-cycle fetch/execute sequencer for the 9-bit-ISA core.

---
 rtl/instr_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/execute sequencer for the 9-bit-ISA core.
// Walks each instruction through FETCH -> EXEC (-> MEM) and drives the PC and the
// instruction-memory read strobe. From the decoder flags it issues the register-write
// strobe, runs the data-memory handshake with a timeout, and stops in HALT on the
// done instruction or on an error. It also keeps saturating cycle and retired-instruction
// counters for benchmarking.
module instr_sequencer #(
    parameter int PC_W        = 10,
    parameter int BR_W        = 6,
    parameter int START_PC    = 0,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              imem_rd,
    output logic [PC_W-1:0]   pc,
    input  logic              dec_branch,
    input  logic              dec_write_en,
    input  logic              dec_mem_read,
    input  logic              dec_mem_write,
    input  logic              dec_done,
    input  logic              br_taken,
    input  logic [BR_W-1:0]   br_offset,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic              reg_we,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instr_cnt
);

    // The wait counter holds the number of MEM cycles already spent without an ack,
    // so it only has to reach MEM_TIMEOUT-1. The timeout fires in the MEM cycle where
    // the counter holds that value and there is still no ack.
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [PC_W-1:0]   START_PC_V = PC_W'(START_PC);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam int EXT_W = PC_W - BR_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t             state_reg, state_next;
    logic [PC_W-1:0]    pc_reg, pc_next;
    logic               err_reg, err_next;
    logic [CNT_W-1:0]   cycle_cnt_reg, cycle_cnt_next;
    logic [CNT_W-1:0]   instr_cnt_reg, instr_cnt_next;
    logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic               load_reg, load_next;
    logic               start_low_reg;

    logic               start_rise;
    logic               retire;
    logic [PC_W-1:0]    pc_plus_one;
    logic [PC_W-1:0]    pc_branch;
    logic [PC_W-1:0]    br_offset_ext;

    // Saturating increment shared by both benchmark counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // start_low_reg records that start was seen low in the previous cycle. It powers up
    // cleared, so a start held high through reset release is not treated as a new edge
    // until it has been observed low once.
    assign start_rise = start & start_low_reg;

    // Sign-extended branch offset; both PC candidates wrap naturally at 2^PC_W.
    assign br_offset_ext = {{EXT_W{br_offset[BR_W-1]}}, br_offset};
    assign pc_plus_one   = pc_reg + PC_W'(1);
    assign pc_branch     = pc_reg + br_offset_ext;

    // Moore outputs decoded directly from the state register.
    assign imem_rd   = (state_reg == S_FETCH);
    assign mem_req   = (state_reg == S_MEM);
    assign busy      = (state_reg == S_FETCH) || (state_reg == S_EXEC) || (state_reg == S_MEM);
    assign done      = (state_reg == S_HALT);
    assign err       = err_reg;
    assign pc        = pc_reg;
    assign cycle_cnt = cycle_cnt_reg;
    assign instr_cnt = instr_cnt_reg;

    // Register stage: state, PC, error flag, counters and the start-edge history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            pc_reg        <= START_PC_V;
            err_reg       <= 1'b0;
            cycle_cnt_reg <= '0;
            instr_cnt_reg <= '0;
            wait_cnt_reg  <= '0;
            load_reg      <= 1'b0;
            start_low_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            err_reg       <= err_next;
            cycle_cnt_reg <= cycle_cnt_next;
            instr_cnt_reg <= instr_cnt_next;
            wait_cnt_reg  <= wait_cnt_next;
            load_reg      <= load_next;
            start_low_reg <= ~start;
        end
    end

    // Next-state logic, PC update, register-write strobe and counter updates.
    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        err_next       = err_reg;
        instr_cnt_next = instr_cnt_reg;
        wait_cnt_next  = wait_cnt_reg;
        load_next      = load_reg;
        reg_we         = 1'b0;
        retire         = 1'b0;
        cycle_cnt_next = busy ? sat_inc(cycle_cnt_reg) : cycle_cnt_reg;

        case (state_reg)
            S_IDLE, S_HALT: begin
                if (start_rise) begin
                    state_next     = S_FETCH;
                    pc_next        = START_PC_V;
                    err_next       = 1'b0;
                    cycle_cnt_next = '0;
                    instr_cnt_next = '0;
                end
            end

            S_FETCH: begin
                state_next = S_EXEC;
            end

            S_EXEC: begin
                if (dec_done) begin
                    // The done instruction retires but leaves the PC pointing at itself.
                    state_next = S_HALT;
                    retire     = 1'b1;
                end else if (dec_mem_read && dec_mem_write) begin
                    // A combined load+store cannot be sequenced; stop and flag it.
                    state_next = S_HALT;
                    err_next   = 1'b1;
                end else if (dec_mem_read || dec_mem_write) begin
                    // The load/store distinction is latched here so the ack cycle does
                    // not depend on the decoder output staying stable during MEM.
                    state_next    = S_MEM;
                    wait_cnt_next = '0;
                    load_next     = dec_mem_read;
                end else begin
                    reg_we     = dec_write_en;
                    pc_next    = (dec_branch && br_taken) ? pc_branch : pc_plus_one;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
            end

            S_MEM: begin
                // An ack in the last permitted cycle still completes the access.
                if (mem_ack) begin
                    reg_we     = load_reg;
                    pc_next    = pc_plus_one;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    err_next   = 1'b1;
                    state_next = S_HALT;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (retire) begin
            instr_cnt_next = sat_inc(instr_cnt_reg);
        end
    end

endmodule
